// File: rtl/micro_sequencer_pkg.sv
// Shared control-unit definitions: micro-address geometry, next-address select
// encodings, error codes and sequencer state encodings.
package micro_sequencer_pkg;

    localparam int UADDR_W    = 5;
    localparam int FETCH_ADDR = 0;
    // Must agree with the default output of the opcode map.
    localparam int NOMAP_ADDR = 31;

    localparam logic [2:0] NS_INC  = 3'b000;
    localparam logic [2:0] NS_MAP  = 3'b001;
    localparam logic [2:0] NS_JMP  = 3'b010;
    localparam logic [2:0] NS_JZ   = 3'b011;
    localparam logic [2:0] NS_JNZ  = 3'b100;
    localparam logic [2:0] NS_CALL = 3'b101;
    localparam logic [2:0] NS_RET  = 3'b110;
    localparam logic [2:0] NS_HALT = 3'b111;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_NOMAP = 2'b01;
    localparam logic [1:0] ERR_OVFL  = 2'b10;
    localparam logic [1:0] ERR_UNFL  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_WAIT = 2'b01,
        ST_HALT = 2'b10
    } seq_state_t;

endpackage

// File: rtl/micro_sequencer_ret_stack.sv
// Return-address LIFO. Implemented as a shift stack so the top entry is always
// slot 0 and no occupancy-indexed read mux is needed.
module ret_stack #(
    parameter int DEPTH = 2,
    parameter int W     = 5,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (push && (cnt_q != FULL_CNT)) begin
            cnt_q <= cnt_q + 1'b1;
        end else if (pop && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Entries carry no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && (cnt_q != FULL_CNT)) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                mem[i] <= mem[i-1];
            end
            mem[0] <= din;
        end else if (pop && (cnt_q != '0)) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem[i] <= mem[i+1];
            end
        end
    end

    assign dout  = mem[0];
    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: owns the micro-PC, stalls on memory handshakes,
// supports call/return and halts with an error code on misuse.
module micro_sequencer
    import micro_sequencer_pkg::*;
#(
    parameter int UADDR_W     = micro_sequencer_pkg::UADDR_W,
    parameter int FETCH_ADDR  = micro_sequencer_pkg::FETCH_ADDR,
    parameter int NOMAP_ADDR  = micro_sequencer_pkg::NOMAP_ADDR,
    parameter int STACK_DEPTH = 2,
    parameter int SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [UADDR_W-1:0] map_addr,
    input  logic [2:0]         nxt_sel,
    input  logic [UADDR_W-1:0] jmp_addr,
    input  logic               zflag,
    input  logic               mem_req,
    input  logic               mem_ack,
    output logic [UADDR_W-1:0] upc,
    output logic               stall,
    output logic               halted,
    output logic [1:0]         err,
    output logic [SP_W-1:0]    sp
);

    localparam logic [UADDR_W-1:0] FETCH_UA = UADDR_W'(FETCH_ADDR);
    localparam logic [UADDR_W-1:0] NOMAP_UA = UADDR_W'(NOMAP_ADDR);

    seq_state_t         state_q, state_d;
    logic [UADDR_W-1:0] upc_q, upc_d;
    logic [1:0]         err_q, err_d;
    logic [UADDR_W-1:0] upc_inc;
    logic [UADDR_W-1:0] stk_top;
    logic               stk_push, stk_pop, stk_full, stk_empty;
    logic               apply;

    assign upc_inc = upc_q + 1'b1;

    // The rule fires on an enabled edge in RUN unless the access is still
    // outstanding, or in WAIT once the ack arrives.
    assign apply = en && (((state_q == ST_RUN) && !(mem_req && !mem_ack)) ||
                          ((state_q == ST_WAIT) && mem_ack));

    always_comb begin
        state_d  = state_q;
        upc_d    = upc_q;
        err_d    = err_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        if (en && (state_q == ST_RUN) && mem_req && !mem_ack) begin
            state_d = ST_WAIT;
        end else if (apply) begin
            state_d = ST_RUN;
            case (nxt_sel)
                NS_INC: upc_d = upc_inc;
                NS_MAP: begin
                    if (map_addr == NOMAP_UA) begin
                        state_d = ST_HALT;
                        err_d   = ERR_NOMAP;
                    end else begin
                        upc_d = map_addr;
                    end
                end
                NS_JMP: upc_d = jmp_addr;
                NS_JZ:  upc_d = zflag ? jmp_addr : upc_inc;
                NS_JNZ: upc_d = zflag ? upc_inc : jmp_addr;
                NS_CALL: begin
                    if (stk_full) begin
                        state_d = ST_HALT;
                        err_d   = ERR_OVFL;
                    end else begin
                        stk_push = 1'b1;
                        upc_d    = jmp_addr;
                    end
                end
                NS_RET: begin
                    if (stk_empty) begin
                        state_d = ST_HALT;
                        err_d   = ERR_UNFL;
                    end else begin
                        stk_pop = 1'b1;
                        upc_d   = stk_top;
                    end
                end
                default: begin
                    state_d = ST_HALT;
                    err_d   = ERR_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            upc_q   <= FETCH_UA;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            err_q   <= err_d;
        end
    end

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (UADDR_W),
        .CW    (SP_W)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (upc_inc),
        .dout  (stk_top),
        .full  (stk_full),
        .empty (stk_empty),
        .count (sp)
    );

    assign upc    = upc_q;
    assign err    = err_q;
    assign stall  = (state_q == ST_WAIT);
    assign halted = (state_q == ST_HALT);

endmodule
